// File: rtl/barcode_entry_ctrl.sv
// Keypad-to-barcode entry controller: steers digits into the 4-digit shift register,
// handles CLEAR/ENTER/inactivity timeout and the price lookup REQ/ACK handshake.
module barcode_entry_ctrl #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter logic [3:0]  BLANK_CODE     = 4'd12
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       KEY_VALID,
  input  logic [3:0] KEY_CODE,
  input  logic       LOOKUP_ACK,
  output logic       SR_ENABLE,
  output logic [3:0] SR_DIGIT,
  output logic       SR_CLEAR_N,
  output logic [2:0] DIGIT_COUNT,
  output logic       LOOKUP_REQ,
  output logic       KEY_ERROR,
  output logic       TIMEOUT
);

  localparam int unsigned TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  COUNT_FULL = 3'(NUM_DIGITS);

  localparam logic [3:0] CODE_CLEAR = 4'd10;
  localparam logic [3:0] CODE_ENTER = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_FULL,
    ST_REQUEST
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sr_enable_q, sr_enable_d;
  logic [3:0]    sr_digit_q, sr_digit_d;
  logic          sr_clear_n_q, sr_clear_n_d;
  logic          lookup_req_q, lookup_req_d;
  logic          key_error_q, key_error_d;
  logic          timeout_q, timeout_d;

  logic is_digit, is_clear, is_enter;
  logic [2:0] count_inc;

  assign is_digit  = KEY_VALID && (KEY_CODE <= 4'd9);
  assign is_clear  = KEY_VALID && (KEY_CODE == CODE_CLEAR);
  assign is_enter  = KEY_VALID && (KEY_CODE == CODE_ENTER);
  assign count_inc = count_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    timer_d      = timer_q;
    sr_enable_d  = 1'b0;
    sr_digit_d   = sr_digit_q;
    sr_clear_n_d = 1'b1;
    lookup_req_d = lookup_req_q;
    key_error_d  = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      ST_REQUEST: begin
        // Keys are dropped while waiting; ACK wins over any simultaneous key.
        timer_d = '0;
        if (LOOKUP_ACK) begin
          lookup_req_d = 1'b0;
          sr_clear_n_d = 1'b0;
          count_d      = 3'd0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        if (state_q == ST_IDLE) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end

        if (is_digit) begin
          timer_d = '0;
          if (count_q < COUNT_FULL) begin
            sr_enable_d = 1'b1;
            sr_digit_d  = KEY_CODE;
            count_d     = count_inc;
            state_d     = (count_inc == COUNT_FULL) ? ST_FULL : ST_ENTRY;
          end else begin
            key_error_d = 1'b1;
          end
        end else if (is_clear) begin
          timer_d      = '0;
          sr_clear_n_d = 1'b0;
          count_d      = 3'd0;
          state_d      = ST_IDLE;
        end else if (is_enter) begin
          timer_d = '0;
          if (count_q == COUNT_FULL) begin
            lookup_req_d = 1'b1;
            state_d      = ST_REQUEST;
          end else begin
            key_error_d = 1'b1;
          end
        end else if ((state_q != ST_IDLE) && (timer_q == TIMER_LAST)) begin
          // Codes 12-15 are not activity, so they do not hold off the timeout.
          timer_d      = '0;
          timeout_d    = 1'b1;
          sr_clear_n_d = 1'b0;
          count_d      = 3'd0;
          state_d      = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      count_q      <= 3'd0;
      timer_q      <= '0;
      sr_enable_q  <= 1'b0;
      sr_digit_q   <= BLANK_CODE;
      sr_clear_n_q <= 1'b0;
      lookup_req_q <= 1'b0;
      key_error_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      sr_enable_q  <= sr_enable_d;
      sr_digit_q   <= sr_digit_d;
      sr_clear_n_q <= sr_clear_n_d;
      lookup_req_q <= lookup_req_d;
      key_error_q  <= key_error_d;
      timeout_q    <= timeout_d;
    end
  end

  assign SR_ENABLE   = sr_enable_q;
  assign SR_DIGIT    = sr_digit_q;
  assign SR_CLEAR_N  = sr_clear_n_q;
  assign DIGIT_COUNT = count_q;
  assign LOOKUP_REQ  = lookup_req_q;
  assign KEY_ERROR   = key_error_q;
  assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_barcode_entry_ctrl.sv
// Directed bench for barcode_entry_ctrl with a short timeout so the idle
// abandonment path can be exercised in a few cycles.
module tb_barcode_entry_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       LOOKUP_ACK;
  logic       SR_ENABLE;
  logic [3:0] SR_DIGIT;
  logic       SR_CLEAR_N;
  logic [2:0] DIGIT_COUNT;
  logic       LOOKUP_REQ;
  logic       KEY_ERROR;
  logic       TIMEOUT;

  int errors = 0;
  int checks = 0;

  barcode_entry_ctrl #(
    .NUM_DIGITS    (4),
    .TIMEOUT_CYCLES(16),
    .BLANK_CODE    (4'd12)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .KEY_VALID  (KEY_VALID),
    .KEY_CODE   (KEY_CODE),
    .LOOKUP_ACK (LOOKUP_ACK),
    .SR_ENABLE  (SR_ENABLE),
    .SR_DIGIT   (SR_DIGIT),
    .SR_CLEAR_N (SR_CLEAR_N),
    .DIGIT_COUNT(DIGIT_COUNT),
    .LOOKUP_REQ (LOOKUP_REQ),
    .KEY_ERROR  (KEY_ERROR),
    .TIMEOUT    (TIMEOUT)
  );

  always #5 CLOCK = ~CLOCK;

  // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic valid, input logic [3:0] code, input logic ack);
    @(negedge CLOCK);
    KEY_VALID  = valid;
    KEY_CODE   = code;
    LOOKUP_ACK = ack;
    @(posedge CLOCK);
    #1;
    KEY_VALID  = 1'b0;
    KEY_CODE   = 4'd0;
    LOOKUP_ACK = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic en, input logic [3:0] dig, input logic clr_n,
                          input logic [2:0] cnt, input logic req, input logic err, input logic to);
    checkOutput({tag, ".sr_enable"},   32'(SR_ENABLE),   32'(en));
    checkOutput({tag, ".sr_digit"},    32'(SR_DIGIT),    32'(dig));
    checkOutput({tag, ".sr_clear_n"},  32'(SR_CLEAR_N),  32'(clr_n));
    checkOutput({tag, ".digit_count"}, 32'(DIGIT_COUNT), 32'(cnt));
    checkOutput({tag, ".lookup_req"},  32'(LOOKUP_REQ),  32'(req));
    checkOutput({tag, ".key_error"},   32'(KEY_ERROR),   32'(err));
    checkOutput({tag, ".timeout"},     32'(TIMEOUT),     32'(to));
  endtask

  initial begin
    RESET_N    = 1'b0;
    KEY_VALID  = 1'b0;
    KEY_CODE   = 4'd0;
    LOOKUP_ACK = 1'b0;

    // Reset state
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    checkAll("reset", 1'b0, 4'd12, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("post_reset", 1'b0, 4'd12, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    // 1: four digits fill the register
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0);
      checkAll($sformatf("fill_d%0d", i), 1'b1, 4'(i), 1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("full_idle", 1'b0, 4'd4, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);

    // 2: digit in FULL and early ENTER are rejected
    applyStimulus(1'b1, 4'd5, 1'b0);
    checkAll("full_digit_err", 1'b0, 4'd4, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd10, 1'b0);
    checkAll("clear_full", 1'b0, 4'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("clear_release", 1'b0, 4'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd6, 1'b0);
    applyStimulus(1'b1, 4'd7, 1'b0);
    checkAll("two_digits", 1'b1, 4'd7, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd11, 1'b0);
    checkAll("early_enter_err", 1'b0, 4'd7, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("early_enter_after", 1'b0, 4'd7, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd10, 1'b0);
    checkAll("clear_entry", 1'b0, 4'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // 3: lookup handshake, keys ignored while requesting, ACK beats a key
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 1'b0);
    checkAll("req_fill", 1'b1, 4'd4, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd11, 1'b0);
    checkAll("enter_full", 1'b0, 4'd4, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'(i + 2), 1'b0);
      checkAll($sformatf("req_hold%0d", i), 1'b0, 4'd4, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 4'd3, 1'b1);
    checkAll("ack", 1'b0, 4'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("ack_after", 1'b0, 4'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkAll("ack_in_idle", 1'b0, 4'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    // 4: inactivity timeout after 16 idle cycles, and a key on the last cycle saves it
    applyStimulus(1'b1, 4'd7, 1'b0);
    checkAll("to_key7", 1'b1, 4'd7, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkOutput($sformatf("to_wait%0d.timeout", i), 32'(TIMEOUT), 32'd0);
    end
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("to_fire", 1'b0, 4'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("to_after", 1'b0, 4'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'd7, 1'b0);
    for (int i = 1; i < 16; i++) applyStimulus(1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'd8, 1'b0);
    checkAll("to_saved", 1'b1, 4'd8, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("to_restarted", 1'b0, 4'd8, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("to_fire2", 1'b0, 4'd8, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // 5: CLEAR mid-entry, CLEAR in IDLE, ignored code
    applyStimulus(1'b1, 4'd9, 1'b0);
    applyStimulus(1'b1, 4'd8, 1'b0);
    checkAll("clr_two", 1'b1, 4'd8, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd10, 1'b0);
    checkAll("clr_pulse", 1'b0, 4'd8, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd10, 1'b0);
    checkAll("clr_idle", 1'b0, 4'd8, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd13, 1'b0);
    checkAll("code13", 1'b0, 4'd8, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset in the middle of a request
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 1'b0);
    applyStimulus(1'b1, 4'd11, 1'b0);
    checkAll("rst_req_up", 1'b0, 4'd4, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    @(negedge CLOCK);
    #1;
    RESET_N = 1'b0;
    #1;
    checkAll("rst_async", 1'b0, 4'd12, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkAll("rst_recover", 1'b0, 4'd12, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 1'b0);
    checkAll("rst_first_key", 1'b1, 4'd5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
